// File: rtl/sdram_user_responder.sv
// rtl/sdram_user_responder.sv - behavioural SDRAM user-port responder with a one-deep pending slot
// Optional refresh windows are enabled by defining SDRAM_RESP_REFRESH_EN.
module sdram_user_responder #(
   parameter int MEM_AW             = 10,
   parameter int RD_LAT             = 3,
   parameter int WR_LAT             = 2,
   parameter int REF_INTERVAL       = 780,
   parameter int USER_ADDRESS_WIDTH = 16
) (
   input  logic                          clk_SDRAM,
   input  logic                          rst,
   input  logic [USER_ADDRESS_WIDTH-1:0] addr_SDRAM,
   input  logic                          re_SDRAM,
   input  logic                          we_SDRAM,
   input  logic [15:0]                   data_write_SDRAM,
   output logic [15:0]                   data_read_SDRAM,
   output logic                          valid_SDRAM,
   output logic                          done_SDRAM,
   output logic                          busy_SDRAM,
   output logic                          drop_SDRAM
);

   localparam int                          AW       = USER_ADDRESS_WIDTH;
   localparam logic [3:0]                  RD_CNT0  = 4'(RD_LAT - 2);
   localparam logic [3:0]                  WR_CNT0  = 4'(WR_LAT - 1);
   localparam logic [AW-1:0]               ADDR_ONE = AW'(1);

   if (RD_LAT < 2 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15 || REF_INTERVAL < 1) begin : g_bad_param
      $error("sdram_user_responder: parameter out of legal range");
   end

`ifdef SDRAM_RESP_REFRESH_EN
   typedef enum logic [2:0] {
      IDLE, WR_BEAT1, WR_WAIT, RD_WAIT, RD_BEAT0, RD_BEAT1, REFRESH
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, WR_BEAT1, WR_WAIT, RD_WAIT, RD_BEAT0, RD_BEAT1
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d, addr_inc;
   logic [15:0]     wd1_q, wd1_d;
   logic            wd1_hold_q, wd1_hold_d;

   logic            pend_vld_q, pend_vld_d;
   logic            pend_wr_q, pend_wr_d;
   logic            pend_need1_q, pend_need1_d;
   logic [AW-1:0]   pend_addr_q, pend_addr_d;
   logic [15:0]     pend_d0_q, pend_d0_d;
   logic [15:0]     pend_d1_q, pend_d1_d;

   logic [15:0]     rdata_q, rdata_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            drop_q, drop_d;

   logic [15:0]     mem_q [2**MEM_AW];
   logic            mem_we;
   logic [MEM_AW-1:0] mem_widx;
   logic [15:0]     mem_wdata;

   logic            cmd_any, can_direct, start, st_wr, st_hold;
   logic [AW-1:0]   st_addr;
   logic [15:0]     st_d0, st_d1;
   logic            ref_take;

   assign addr_inc = addr_q + ADDR_ONE;

`ifdef SDRAM_RESP_REFRESH_EN
   localparam int REF_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

   logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
   logic             ref_req_q, ref_req_d, ref_wrap;

   // Free-running interval counter; a window that lands mid-operation waits as ref_req_q.
   always_comb begin
      ref_wrap  = (ref_cnt_q == REF_W'(REF_INTERVAL - 1));
      ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
      ref_req_d = (ref_req_q & ~ref_take) | ref_wrap;
   end

   assign ref_take = ref_req_q && (state_q == IDLE);

   always_ff @(posedge clk_SDRAM) begin
      if (rst) begin
         ref_cnt_q <= '0;
         ref_req_q <= 1'b0;
      end else begin
         ref_cnt_q <= ref_cnt_d;
         ref_req_q <= ref_req_d;
      end
   end
`else
   assign ref_take = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wd1_d        = wd1_q;
      wd1_hold_d   = wd1_hold_q;
      pend_vld_d   = pend_vld_q;
      pend_wr_d    = pend_wr_q;
      pend_need1_d = 1'b0;
      pend_addr_d  = pend_addr_q;
      pend_d0_d    = pend_d0_q;
      pend_d1_d    = pend_need1_q ? data_write_SDRAM : pend_d1_q;
      rdata_d      = '0;
      drop_d       = 1'b0;
      mem_we       = 1'b0;
      mem_widx     = addr_q[MEM_AW-1:0];
      mem_wdata    = data_write_SDRAM;
      start        = 1'b0;
      st_wr        = we_SDRAM;
      st_addr      = addr_SDRAM;
      st_d0        = data_write_SDRAM;
      st_d1        = data_write_SDRAM;
      st_hold      = 1'b0;
      cmd_any      = re_SDRAM | we_SDRAM;
      can_direct   = (state_q == IDLE) && !pend_vld_q && !ref_take;

      case (state_q)
         IDLE: begin
`ifdef SDRAM_RESP_REFRESH_EN
            if (ref_take) begin
               state_d = REFRESH;
               cnt_d   = 4'd7;
            end else
`endif
            if (pend_vld_q) begin
               // Beat 1 of a pending write may still be on the bus this very cycle.
               start      = 1'b1;
               st_wr      = pend_wr_q;
               st_addr    = pend_addr_q;
               st_d0      = pend_d0_q;
               st_d1      = pend_need1_q ? data_write_SDRAM : pend_d1_q;
               st_hold    = 1'b1;
               pend_vld_d = 1'b0;
            end else if (cmd_any) begin
               start = 1'b1;
            end
         end
         WR_BEAT1: begin
            mem_we    = 1'b1;
            mem_widx  = addr_inc[MEM_AW-1:0];
            mem_wdata = wd1_hold_q ? wd1_q : data_write_SDRAM;
            state_d   = WR_WAIT;
            cnt_d     = WR_CNT0;
         end
         WR_WAIT: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RD_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RD_BEAT0;
               rdata_d = mem_q[addr_q[MEM_AW-1:0]];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_BEAT0: begin
            state_d = RD_BEAT1;
            rdata_d = mem_q[addr_inc[MEM_AW-1:0]];
         end
         RD_BEAT1: state_d = IDLE;
`ifdef SDRAM_RESP_REFRESH_EN
         REFRESH: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
`endif
         default: state_d = IDLE;
      endcase

      if (start) begin
         addr_d = st_addr;
         if (st_wr) begin
            mem_we     = 1'b1;
            mem_widx   = st_addr[MEM_AW-1:0];
            mem_wdata  = st_d0;
            wd1_d      = st_d1;
            wd1_hold_d = st_hold;
            state_d    = WR_BEAT1;
         end else begin
            state_d = RD_WAIT;
            cnt_d   = RD_CNT0;
         end
      end

      // A simultaneous read+write keeps the write and reports the lost read.
      if (cmd_any && !can_direct) begin
         if (pend_vld_q) begin
            drop_d = 1'b1;
         end else begin
            pend_vld_d   = 1'b1;
            pend_wr_d    = we_SDRAM;
            pend_need1_d = we_SDRAM;
            pend_addr_d  = addr_SDRAM;
            pend_d0_d    = data_write_SDRAM;
            drop_d       = re_SDRAM & we_SDRAM;
         end
      end else if (cmd_any) begin
         drop_d = re_SDRAM & we_SDRAM;
      end

      valid_d = (state_d == RD_BEAT0) || (state_d == RD_BEAT1);
      done_d  = (state_d == WR_WAIT) && (cnt_d == 4'd0);
      busy_d  = (state_d != IDLE) || pend_vld_d;
   end

   always_ff @(posedge clk_SDRAM) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wd1_q        <= '0;
         wd1_hold_q   <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_need1_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_d0_q    <= '0;
         pend_d1_q    <= '0;
         rdata_q      <= '0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wd1_q        <= wd1_d;
         wd1_hold_q   <= wd1_hold_d;
         pend_vld_q   <= pend_vld_d;
         pend_wr_q    <= pend_wr_d;
         pend_need1_q <= pend_need1_d;
         pend_addr_q  <= pend_addr_d;
         pend_d0_q    <= pend_d0_d;
         pend_d1_q    <= pend_d1_d;
         rdata_q      <= rdata_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         drop_q       <= drop_d;
      end
   end

   // Array contents survive reset; only the write strobe is gated.
   always_ff @(posedge clk_SDRAM) begin
      if (!rst && mem_we) mem_q[mem_widx] <= mem_wdata;
   end

   assign data_read_SDRAM = rdata_q;
   assign valid_SDRAM     = valid_q;
   assign done_SDRAM      = done_q;
   assign busy_SDRAM      = busy_q;
   assign drop_SDRAM      = drop_q;

endmodule

// File: tb/tb_sdram_user_responder.sv
// tb/tb_sdram_user_responder.sv - randomized bench for sdram_user_responder against a transaction schedule model
module tb_sdram_user_responder;

   localparam int MEM_AW = 10;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 2;
   localparam int N      = 700;
   localparam int NA     = N + 24;

   logic        clk_SDRAM = 1'b0;
   logic        rst;
   logic [15:0] addr_SDRAM;
   logic        re_SDRAM, we_SDRAM;
   logic [15:0] data_write_SDRAM;
   logic [15:0] data_read_SDRAM;
   logic        valid_SDRAM, done_SDRAM, busy_SDRAM, drop_SDRAM;

   always #5 clk_SDRAM = ~clk_SDRAM;

   sdram_user_responder #(
      .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .REF_INTERVAL(780)
   ) dut (
      .clk_SDRAM        (clk_SDRAM),
      .rst              (rst),
      .addr_SDRAM       (addr_SDRAM),
      .re_SDRAM         (re_SDRAM),
      .we_SDRAM         (we_SDRAM),
      .data_write_SDRAM (data_write_SDRAM),
      .data_read_SDRAM  (data_read_SDRAM),
      .valid_SDRAM      (valid_SDRAM),
      .done_SDRAM       (done_SDRAM),
      .busy_SDRAM       (busy_SDRAM),
      .drop_SDRAM       (drop_SDRAM)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // stimulus per cycle
   bit          s_rst [NA];
   bit          s_re  [NA];
   bit          s_we  [NA];
   logic [15:0] s_addr[NA];
   logic [15:0] s_din [NA];

   // expected outputs per cycle
   bit          e_valid[NA];
   bit          e_done [NA];
   bit          e_drop [NA];
   bit          e_busy [NA];
   logic [15:0] e_data [NA];

   logic [15:0] m_mem [2**MEM_AW];
   int          free_at;
   bit          b1v;
   logic [15:0] b1a, b1d;

   function automatic int idx(input logic [15:0] a);
      return int'(a[MEM_AW-1:0]);
   endfunction

   task automatic put_cmd(input int c, input bit re, input bit we, input logic [15:0] a,
                          input logic [15:0] d0, input logic [15:0] d1);
      s_re[c] = re; s_we[c] = we; s_addr[c] = a; s_din[c] = d0; s_din[c+1] = d1;
   endtask

   // Operation start: a write occupies 2+WR_LAT cycles, a read RD_LAT+2.
   task automatic start_op(input int s, input bit wr, input logic [15:0] a,
                           input logic [15:0] d0, input logic [15:0] d1);
      logic [15:0] a1;
      a1 = a + 16'd1;
      if (wr) begin
         m_mem[idx(a)] = d0;
         b1v = 1'b1; b1a = a1; b1d = d1;
         e_done[s+1+WR_LAT] = 1'b1;
         free_at = s + 2 + WR_LAT;
      end else begin
         e_valid[s+RD_LAT]   = 1'b1; e_data[s+RD_LAT]   = m_mem[idx(a)];
         e_valid[s+RD_LAT+1] = 1'b1; e_data[s+RD_LAT+1] = m_mem[idx(a1)];
         free_at = s + RD_LAT + 2;
      end
   endtask

   task automatic run_model();
      bit          pv, pwr, cmd;
      logic [15:0] pa, pd0, pd1;
      pv = 0; pwr = 0; pa = '0; pd0 = '0; pd1 = '0;
      free_at = 0; b1v = 0;
      for (int c = 0; c < N; c++) begin
         if (s_rst[c]) begin
            for (int k = c + 1; k < NA; k++) begin
               e_valid[k] = 0; e_done[k] = 0;
            end
            free_at = c + 1; pv = 0; b1v = 0;
            e_busy[c+1] = 0;
            continue;
         end
         if (b1v) begin
            m_mem[idx(b1a)] = b1d;
            b1v = 0;
         end
         cmd = s_re[c] | s_we[c];
         if (c >= free_at) begin
            if (pv) begin
               start_op(c, pwr, pa, pd0, pd1);
               pv = 0;
               if (cmd) e_drop[c+1] = 1;
            end else if (cmd) begin
               start_op(c, s_we[c], s_addr[c], s_din[c], s_din[c+1]);
               if (s_re[c] && s_we[c]) e_drop[c+1] = 1;
            end
         end else if (cmd) begin
            if (pv) begin
               e_drop[c+1] = 1;
            end else begin
               pv = 1; pwr = s_we[c]; pa = s_addr[c]; pd0 = s_din[c]; pd1 = s_din[c+1];
               if (s_re[c] && s_we[c]) e_drop[c+1] = 1;
            end
         end
         e_busy[c+1] = (c + 1 < free_at) || pv;
      end
   endtask

   task automatic apply(input int c);
      rst = s_rst[c]; re_SDRAM = s_re[c]; we_SDRAM = s_we[c];
      addr_SDRAM = s_addr[c]; data_write_SDRAM = s_din[c];
   endtask

   logic [15:0] addr_pool [10];

   initial begin
      addr_pool[0] = 16'h0000; addr_pool[1] = 16'h0001; addr_pool[2] = 16'h0002;
      addr_pool[3] = 16'h0003; addr_pool[4] = 16'h0004; addr_pool[5] = 16'h0005;
      addr_pool[6] = 16'h0006; addr_pool[7] = 16'hFFFF; addr_pool[8] = 16'h03FF;
      addr_pool[9] = 16'h0400;
      for (int c = 0; c < NA; c++) begin
         s_rst[c] = 0; s_re[c] = 0; s_we[c] = 0; s_addr[c] = '0; s_din[c] = '0;
         e_valid[c] = 0; e_done[c] = 0; e_drop[c] = 0; e_busy[c] = 0; e_data[c] = '0;
      end
      s_rst[0] = 1; s_rst[1] = 1;

      put_cmd(4,  0, 1, 16'h0000, 16'h5678, 16'h1234);
      put_cmd(10, 1, 0, 16'h0000, 16'h0000, 16'h0000);
      put_cmd(16, 0, 1, 16'hFFFF, 16'hAAAA, 16'hBBBB);
      put_cmd(22, 1, 0, 16'hFFFF, 16'h0000, 16'h0000);
      put_cmd(28, 0, 1, 16'h0004, 16'h4444, 16'h5555);
      put_cmd(34, 0, 1, 16'h0002, 16'h1111, 16'h2222);
      put_cmd(36, 1, 0, 16'h0002, 16'h0000, 16'h0000);
      put_cmd(37, 0, 1, 16'h0005, 16'h7777, 16'h7878);
      put_cmd(46, 1, 0, 16'h0004, 16'h0000, 16'h0000);
      put_cmd(52, 1, 1, 16'h0006, 16'h6666, 16'h6767);
      put_cmd(58, 1, 0, 16'h0006, 16'h0000, 16'h0000);
      put_cmd(64, 1, 0, 16'h0000, 16'h0000, 16'h0000);
      s_rst[65] = 1;

      for (int c = 72; c < N - 12; c++) begin
         s_din[c]  = 16'($urandom);
         s_re[c]   = ($urandom_range(0, 4) == 0);
         s_we[c]   = ($urandom_range(0, 4) == 0);
         s_addr[c] = addr_pool[$urandom_range(0, 9)];
         s_rst[c]  = ($urandom_range(0, 149) == 0);
      end

      run_model();

      apply(0);
      for (int c = 1; c < N; c++) begin
         @(posedge clk_SDRAM);
         #1;
         apply(c);
         @(negedge clk_SDRAM);
         check_eq($sformatf("valid@%0d", c), valid_SDRAM, e_valid[c]);
         check_eq($sformatf("done@%0d", c),  done_SDRAM,  e_done[c]);
         check_eq($sformatf("drop@%0d", c),  drop_SDRAM,  e_drop[c]);
         check_eq($sformatf("busy@%0d", c),  busy_SDRAM,  e_busy[c]);
         if (e_valid[c]) check_eq($sformatf("rdata@%0d", c), data_read_SDRAM, e_data[c]);
         case (c)
            1:  check_eq("reset_rdata", data_read_SDRAM, 16'h0000);
            6:  check_eq("wr_done_early", done_SDRAM, 1'b0);
            7:  check_eq("wr_done_t3", done_SDRAM, 1'b1);
            8:  check_eq("wr_done_late", done_SDRAM, 1'b0);
            12: check_eq("rd_valid_early", valid_SDRAM, 1'b0);
            13: check_eq("rd_beat0", {valid_SDRAM, data_read_SDRAM}, {1'b1, 16'h5678});
            14: check_eq("rd_beat1", {valid_SDRAM, data_read_SDRAM}, {1'b1, 16'h1234});
            15: check_eq("rd_valid_late", valid_SDRAM, 1'b0);
            25: check_eq("wrap_beat0", data_read_SDRAM, 16'hAAAA);
            26: check_eq("wrap_beat1", data_read_SDRAM, 16'hBBBB);
            37: check_eq("pend_busy", busy_SDRAM, 1'b1);
            38: check_eq("third_drop", drop_SDRAM, 1'b1);
            41: check_eq("raw_beat0", data_read_SDRAM, 16'h1111);
            42: check_eq("raw_beat1", data_read_SDRAM, 16'h2222);
            50: check_eq("dropped_not_run", data_read_SDRAM, 16'h5555);
            53: check_eq("both_drop", drop_SDRAM, 1'b1);
            55: check_eq("both_done", done_SDRAM, 1'b1);
            56: check_eq("both_no_valid0", valid_SDRAM, 1'b0);
            57: check_eq("both_no_valid1", valid_SDRAM, 1'b0);
            61: check_eq("both_wrote", data_read_SDRAM, 16'h6666);
            67: check_eq("rst_abandon0", valid_SDRAM, 1'b0);
            68: check_eq("rst_abandon1", valid_SDRAM, 1'b0);
            default: ;
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_user_responder.md
SDRAM_USER_RESPONDER -- requirements
Module: sdram_user_responder

Interface
REQ-001 Parameter MEM_AW, default 10: backing-array address width; depth is 2^MEM_AW x 16 bits.
REQ-002 Parameter RD_LAT, default 3, legal range 2..15: cycles from read acceptance to the first valid_SDRAM beat.
REQ-003 Parameter WR_LAT, default 2, legal range 1..15: cycles from the second write beat to done_SDRAM.
REQ-004 Parameter REF_INTERVAL, default 780: cycles between refresh windows (used only when the refresh macro is defined).
REQ-005 Port clk_SDRAM, in, 1: the only clock; all logic is on its rising edge.
REQ-006 Port rst, in, 1: reset, synchronous and active-high.
REQ-007 Port addr_SDRAM, in, USER_ADDRESS_WIDTH (from SDRAM_params): 16-bit word address of the command.
REQ-008 Port re_SDRAM, in, 1: single-cycle read command pulse.
REQ-009 Port we_SDRAM, in, 1: single-cycle write command pulse.
REQ-010 Port data_write_SDRAM, in, 16: write data; beat 0 in the command cycle, beat 1 in the next cycle.
REQ-011 Port data_read_SDRAM, out, 16: read data; meaningful only while valid_SDRAM=1.
REQ-012 Port valid_SDRAM, out, 1: read beat valid.
REQ-013 Port done_SDRAM, out, 1: one-cycle pulse marking write completion.
REQ-014 Port busy_SDRAM, out, 1: high in every state other than IDLE, or while the pending slot is full.
REQ-015 Port drop_SDRAM, out, 1: one-cycle pulse when a command is discarded.

Function
REQ-016 The state machine SHALL have the states IDLE, WR_BEAT1, WR_WAIT, RD_WAIT, RD_BEAT0, RD_BEAT1 and REFRESH; all outputs SHALL be registered.
REQ-017 Write: when we_SDRAM=1 is sampled in IDLE at cycle T, the block SHALL write mem[addr] = data_write_SDRAM at T and mem[addr+1] = data_write_SDRAM at T+1 (WR_BEAT1).
REQ-018 After WR_BEAT1, the block SHALL wait in WR_WAIT and pulse done_SDRAM for exactly one cycle, at T+1+WR_LAT, then return to IDLE.
REQ-019 Read: when re_SDRAM=1 is sampled in IDLE at cycle T, valid_SDRAM SHALL be high at T+RD_LAT with mem[addr] and at T+RD_LAT+1 with mem[addr+1], and low otherwise.
REQ-020 addr+1 SHALL wrap modulo 2^USER_ADDRESS_WIDTH; the memory index SHALL be the low MEM_AW bits of the address.
REQ-021 If re_SDRAM and we_SDRAM are sampled high together, the write SHALL be executed, the read discarded, and drop_SDRAM pulsed.
REQ-022 A command arriving while not in IDLE SHALL be latched into a single pending slot, together with its address and beat-0 data.
REQ-023 For a pending write, the slot SHALL also capture beat 1 on the following cycle.
REQ-024 A pending command SHALL start on the first cycle after return to IDLE, with timing per REQ-017..019, measured from that start cycle.
REQ-025 A command arriving while the pending slot is full SHALL be discarded and drop_SDRAM pulsed.
REQ-026 A read issued after a write to the same address SHALL return the newly written data.

Reset
REQ-027 While rst=1: state SHALL be IDLE, the pending slot SHALL be cleared, and valid_SDRAM, done_SDRAM, busy_SDRAM, drop_SDRAM and data_read_SDRAM SHALL all be 0.
REQ-028 Reset during any operation SHALL abandon it; no valid_SDRAM or done_SDRAM pulse for that operation SHALL appear after reset is released.
REQ-029 Memory contents are not reset; a partially completed write SHALL leave beat 0 written.

Configuration
REQ-030 Macro SDRAM_RESP_REFRESH_EN, when defined, SHALL add a refresh counter that enters REFRESH for 8 cycles every REF_INTERVAL cycles.
REQ-031 Refresh SHALL be taken only from IDLE, deferred until an in-flight operation completes; commands arriving during REFRESH SHALL use the pending slot.
REQ-032 Without SDRAM_RESP_REFRESH_EN, the REFRESH state and the counter SHALL be absent and timing SHALL be exactly per REQ-017..019.

Verification
REQ-033 we=1 at T, addr=0, data 5678h then 1234h -> done=1 only at T+3 (WR_LAT=2); mem[0]=5678h, mem[1]=1234h.
REQ-034 re=1 at T, addr=0 after REQ-033 -> valid=1 at T+3 with 5678h and at T+4 with 1234h, and 0 elsewhere.
REQ-035 Read at addr=all-ones -> beat 1 returns mem[0]; write at addr=all-ones -> second beat lands at mem[0].
REQ-036 Write, then read 2 cycles later, then a third command -> the read is pending and returns the new data after done; the third command gives drop=1 and is never executed.
REQ-037 re and we high together -> the write completes, drop=1 for one cycle, no valid beats; rst=1 at T+1 of a read -> no valid beats ever appear.
REQ-038 With SDRAM_RESP_REFRESH_EN defined and REF_INTERVAL=20, a read issued during REFRESH -> busy=1 and the first valid beat arrives RD_LAT cycles after the window ends.
